// File: rtl/mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit:
// op codes, default latencies and the busy-counter width helper.
package mdu_pkg;

    localparam logic [3:0] MDU_OP_NONE  = 4'd0;
    localparam logic [3:0] MDU_OP_MULT  = 4'd1;
    localparam logic [3:0] MDU_OP_MULTU = 4'd2;
    localparam logic [3:0] MDU_OP_DIV   = 4'd3;
    localparam logic [3:0] MDU_OP_DIVU  = 4'd4;
    localparam logic [3:0] MDU_OP_MTHI  = 4'd5;
    localparam logic [3:0] MDU_OP_MTLO  = 4'd6;
    localparam logic [3:0] MDU_OP_MFHI  = 4'd7;
    localparam logic [3:0] MDU_OP_MFLO  = 4'd8;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Width needed to hold the larger of the two latencies as a down-count.
    function automatic int mdu_cnt_width(input int mult_cycles, input int div_cycles);
        int m;
        m = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no long op in flight; accepts any op when en=1
// RUN     | result parked in pending regs, counting down to commit
//
// The arithmetic is done combinationally on the accept edge and parked in
// pending registers; busy only models the latency the pipeline must see.
// HI/LO change only on the commit edge, so a pending result never leaks out.
module mdu_multicycle
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] result
);

    localparam int CW = mdu_cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    mdu_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0]   pend_lo_q, pend_lo_d;
    logic               pend_skip_q, pend_skip_d;

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               div_signed;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    // Product and quotient/remainder of the current operands, used only at accept.
    // Signed divide works on magnitudes and re-applies signs: this truncates
    // toward zero and gives INT_MIN/-1 -> quotient INT_MIN, remainder 0 without
    // a special case, since -INT_MIN wraps back to INT_MIN.
    always_comb begin
        prod_s     = {{WIDTH{inA[WIDTH-1]}}, inA} * {{WIDTH{inB[WIDTH-1]}}, inB};
        prod_u     = {{WIDTH{1'b0}}, inA} * {{WIDTH{1'b0}}, inB};
        div_signed = (op == MDU_OP_DIV);
        mag_a      = (div_signed && inA[WIDTH-1]) ? -inA : inA;
        mag_b      = (div_signed && inB[WIDTH-1]) ? -inB : inB;
        q_mag      = '0;
        r_mag      = '0;
        if (mag_b != '0) begin
            q_mag = mag_a / mag_b;
            r_mag = mag_a % mag_b;
        end
        quot = (div_signed && (inA[WIDTH-1] ^ inB[WIDTH-1])) ? -q_mag : q_mag;
        rem  = (div_signed && inA[WIDTH-1]) ? -r_mag : r_mag;
    end

    // Next-state: accept in IDLE, count down and commit in RUN.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        pend_hi_d   = pend_hi_q;
        pend_lo_d   = pend_lo_q;
        pend_skip_d = pend_skip_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    case (op)
                        MDU_OP_MULT: begin
                            pend_hi_d   = prod_s[2*WIDTH-1:WIDTH];
                            pend_lo_d   = prod_s[WIDTH-1:0];
                            pend_skip_d = 1'b0;
                            cnt_d       = MULT_LOAD;
                            state_d     = ST_RUN;
                        end
                        MDU_OP_MULTU: begin
                            pend_hi_d   = prod_u[2*WIDTH-1:WIDTH];
                            pend_lo_d   = prod_u[WIDTH-1:0];
                            pend_skip_d = 1'b0;
                            cnt_d       = MULT_LOAD;
                            state_d     = ST_RUN;
                        end
                        MDU_OP_DIV, MDU_OP_DIVU: begin
                            pend_hi_d   = rem;
                            pend_lo_d   = quot;
                            // Divide by zero still burns the full latency but leaves HI/LO alone.
                            pend_skip_d = (inB == '0);
                            cnt_d       = DIV_LOAD;
                            state_d     = ST_RUN;
                        end
                        MDU_OP_MTHI: hi_d = inA;
                        MDU_OP_MTLO: lo_d = inA;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    if (!pend_skip_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
    end

    // All unit state; reset aborts any op in flight without committing it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            pend_hi_q   <= '0;
            pend_lo_q   <= '0;
            pend_skip_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            pend_hi_q   <= pend_hi_d;
            pend_lo_q   <= pend_lo_d;
            pend_skip_q <= pend_skip_d;
        end
    end

    // mfhi/mflo read path; not gated by busy because the hazard unit stalls.
    always_comb begin
        result = '0;
        if (op == MDU_OP_MFHI) result = hi_q;
        else if (op == MDU_OP_MFLO) result = lo_q;
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_multicycle.sv
// Directed bench for mdu_multicycle with a behavioural HI/LO model and
// per-cycle comparison of busy/hi/lo/result.
module tb_mdu_multicycle;

    localparam int W  = 32;
    localparam int NM = 5;
    localparam int ND = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [3:0]    op = 4'd0;
    logic [W-1:0]  inA = '0;
    logic [W-1:0]  inB = '0;
    logic          busy;
    logic [W-1:0]  hi, lo, result;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    mdu_multicycle #(.WIDTH(W), .MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk(clk), .reset(reset), .en(en), .op(op), .inA(inA), .inB(inB),
        .busy(busy), .hi(hi), .lo(lo), .result(result)
    );

    always #5 clk = ~clk;

    // Behavioural model: remaining busy cycles plus the result to apply when they run out.
    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [31:0] p_hi = '0, p_lo = '0;
    bit          p_apply = 1'b0;

    always @(posedge clk) begin
        int          sa, sb;
        longint      ps;
        logic [63:0] pu;
        if (reset) begin
            m_left = 0; m_hi = '0; m_lo = '0; p_apply = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && p_apply) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (en) begin
            sa = inA; sb = inB;
            case (op)
                4'd1: begin
                    ps = longint'(sa) * longint'(sb);
                    p_hi = ps[63:32]; p_lo = ps[31:0]; p_apply = 1'b1; m_left = NM;
                end
                4'd2: begin
                    pu = 64'(inA) * 64'(inB);
                    p_hi = pu[63:32]; p_lo = pu[31:0]; p_apply = 1'b1; m_left = NM;
                end
                4'd3: begin
                    m_left = ND;
                    p_apply = (sb != 0);
                    if (sb == 0) begin
                        p_hi = '0; p_lo = '0;
                    end else if (sa == 32'sh8000_0000 && sb == -1) begin
                        p_lo = 32'h8000_0000; p_hi = '0;
                    end else begin
                        p_lo = sa / sb; p_hi = sa % sb;
                    end
                end
                4'd4: begin
                    m_left = ND;
                    p_apply = (inB != 0);
                    if (inB != 0) begin
                        p_lo = inA / inB; p_hi = inA % inB;
                    end
                end
                4'd5: m_hi = inA;
                4'd6: m_lo = inA;
                default: ;
            endcase
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        logic [31:0] exp_res;
        if (chk_on) begin
            exp_res = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'h0;
            n_tests++;
            if (busy !== (m_left > 0)) begin
                n_fail++; $display("FAIL cyc_busy t=%0t got %0b exp %0b", $time, busy, (m_left > 0));
            end
            n_tests++;
            if (hi !== m_hi) begin
                n_fail++; $display("FAIL cyc_hi t=%0t got %h exp %h", $time, hi, m_hi);
            end
            n_tests++;
            if (lo !== m_lo) begin
                n_fail++; $display("FAIL cyc_lo t=%0t got %h exp %h", $time, lo, m_lo);
            end
            n_tests++;
            if (result !== exp_res) begin
                n_fail++; $display("FAIL cyc_result t=%0t got %h exp %h", $time, result, exp_res);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        en = 1'b1; op = o; inA = a; inB = b;
        @(posedge clk);
        #1;
        en = 1'b0; op = 4'd0; inA = '0; inB = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle(2);
        chk_on = 1'b1;
        reset = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);

        // mthi/mtlo and mfhi/mflo
        issue(4'd5, 32'h1234_5678, 32'h0);
        issue(4'd6, 32'h9ABC_DEF0, 32'h0);
        chk("mt_hi", hi, 32'h1234_5678);
        chk("mt_lo", lo, 32'h9ABC_DEF0);
        op = 4'd7; #1;
        chk("mfhi", result, 32'h1234_5678);
        op = 4'd8; #1;
        chk("mflo", result, 32'h9ABC_DEF0);
        op = 4'd0;
        idle(1);

        // mult -1 * 2, latency boundary
        issue(4'd1, 32'hFFFF_FFFF, 32'h2);
        chk("mult_busy_first", {31'b0, busy}, 32'h1);
        chk("mult_hold_hi", hi, 32'h1234_5678);
        idle(NM - 1);
        chk("mult_busy_last", {31'b0, busy}, 32'h1);
        chk("mult_hold_lo", lo, 32'h9ABC_DEF0);
        idle(1);
        chk("mult_done", {31'b0, busy}, 32'h0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);
        issue(4'd2, 32'hFFFF_FFFF, 32'h2);
        idle(NM);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
        issue(4'd1, 32'h8000_0000, 32'h8000_0000);
        idle(NM);
        chk("mult_min_hi", hi, 32'h4000_0000);
        chk("mult_min_lo", lo, 32'h0);

        // div / divu
        issue(4'd3, 32'hFFFF_FFF9, 32'h2);
        idle(ND - 1);
        chk("div_busy_last", {31'b0, busy}, 32'h1);
        idle(1);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        issue(4'd4, 32'hFFFF_FFF9, 32'h2);
        idle(ND);
        chk("divu_lo", lo, 32'h7FFF_FFFC);
        chk("divu_hi", hi, 32'h1);
        issue(4'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        idle(ND);
        chk("div_nn_lo", lo, 32'h3);
        chk("div_nn_hi", hi, 32'hFFFF_FFFF);

        // divide by zero and signed overflow
        issue(4'd5, 32'hAA, 32'h0);
        issue(4'd6, 32'hBB, 32'h0);
        issue(4'd3, 32'h5, 32'h0);
        idle(ND - 1);
        chk("dz_busy_last", {31'b0, busy}, 32'h1);
        idle(1);
        chk("dz_done", {31'b0, busy}, 32'h0);
        chk("dz_hi", hi, 32'hAA);
        chk("dz_lo", lo, 32'hBB);
        issue(4'd4, 32'h5, 32'h0);
        idle(ND);
        chk("dzu_hi", hi, 32'hAA);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(ND);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'h0);

        // reserved op code is a no-op
        issue(4'd12, 32'h77, 32'h77);
        chk("rsvd_busy", {31'b0, busy}, 32'h0);
        chk("rsvd_lo", lo, 32'h8000_0000);

        // op ignored while busy, back-to-back accept
        issue(4'd1, 32'h3, 32'h4);
        idle(1);
        issue(4'd6, 32'h55, 32'h0);
        idle(NM - 2);
        chk("ign_lo", lo, 32'hC);
        chk("ign_hi", hi, 32'h0);
        issue(4'd4, 32'd100, 32'd7);
        chk("b2b_busy", {31'b0, busy}, 32'h1);
        idle(ND);
        chk("b2b_lo", lo, 32'd14);
        chk("b2b_hi", hi, 32'd2);

        // reset mid-operation
        issue(4'd3, 32'd100, 32'd7);
        idle(3);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        idle(ND);
        chk("late_hi", hi, 32'h0);
        chk("late_lo", lo, 32'h0);
        chk("late_busy", {31'b0, busy}, 32'h0);

        idle(2);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
